// File: rtl/dp_mem_responder.sv
// dp_mem_responder: arbitrates fetch and data requests onto one RAM port.
// Holds a one-entry fetch buffer so repeated fetches of a PC skip the RAM.
module dp_mem_responder #(
    parameter bit FETCH_BUF = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] IFETCH  = 3'd1;
    localparam logic [2:0] DACCESS = 3'd2;
    localparam logic [2:0] RESP    = 3'd3;
    localparam logic [2:0] HALTED  = 3'd4;

    logic [2:0]  state;
    logic [31:0] lat_addr;
    logic        lat_d;
    logic        lat_wr;
    logic        halt_seen;
    logic [31:0] resp_data;
    logic [31:0] iload_q;
    logic [31:0] dload_q;
    logic        buf_valid;
    logic [31:0] buf_tag;
    logic [31:0] buf_data;
    logic        d_req;
    logic        buf_hit;
    logic        d_still;

    assign d_req   = dmemREN | dmemWEN;
    assign buf_hit = FETCH_BUF && buf_valid && (buf_tag == imemaddr);
    assign d_still = lat_wr ? dmemWEN : dmemREN;

    // A response is only delivered if its request is still being presented.
    assign ihit = (state == RESP) && !lat_d
                  && imemREN && (imemaddr == lat_addr);
    assign dhit = (state == RESP) && lat_d
                  && d_still && (dmemaddr == lat_addr);

    assign imemload = ihit ? resp_data : iload_q;
    assign dmemload = (dhit && !lat_wr) ? resp_data : dload_q;

    // Main FSM: request arbitration, RAM strobes and fetch buffer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_d     <= 1'b0;
            lat_wr    <= 1'b0;
            halt_seen <= 1'b0;
            resp_data <= '0;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    halt_seen <= 1'b0;
                    if (halt) begin
                        state <= HALTED;
                    end else if (d_req) begin
                        state    <= DACCESS;
                        lat_d    <= 1'b1;
                        lat_wr   <= dmemWEN;
                        lat_addr <= dmemaddr;
                        ramaddr  <= dmemaddr;
                        ramstore <= dmemstore;
                        ramWEN   <= dmemWEN;
                        ramREN   <= ~dmemWEN;
                        if (dmemWEN && (dmemaddr == buf_tag))
                            buf_valid <= 1'b0;
                    end else if (imemREN && buf_hit) begin
                        state     <= RESP;
                        lat_d     <= 1'b0;
                        lat_wr    <= 1'b0;
                        lat_addr  <= imemaddr;
                        resp_data <= buf_data;
                    end else if (imemREN) begin
                        state    <= IFETCH;
                        lat_d    <= 1'b0;
                        lat_wr   <= 1'b0;
                        lat_addr <= imemaddr;
                        ramaddr  <= imemaddr;
                        ramREN   <= 1'b1;
                    end
                end
                IFETCH, DACCESS: begin
                    if (halt)
                        halt_seen <= 1'b1;
                    if (ramready) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (!lat_wr)
                            resp_data <= ramload;
                        if (!lat_d) begin
                            buf_tag   <= lat_addr;
                            buf_data  <= ramload;
                            buf_valid <= FETCH_BUF;
                        end
                        state <= (halt || halt_seen) ? HALTED : RESP;
                    end
                end
                RESP:    state <= IDLE;
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Load words hold their last delivered value between hits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            if (ihit)
                iload_q <= resp_data;
            if (dhit && !lat_wr)
                dload_q <= resp_data;
        end
    end

endmodule

// File: doc/dp_mem_responder.md
# dp_mem_responder

Memory-side responder for the datapath/cache interface: accepts the pipeline's instruction-fetch and data-access requests, arbitrates them onto one shared single-ported RAM port, and returns single-cycle `ihit`/`dhit` pulses with load data. It sits between the pipelined datapath and the RAM model, standing in for the cache. A one-entry fetch buffer returns repeat fetches of the same PC without a RAM access, for example while the pipeline is stalled on a data access.

## Interface
Parameters:
- `FETCH_BUF`, 1: enables the one-entry instruction fetch buffer; 0 sends every fetch to RAM.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `imemREN` in 1: fetch request.
- `imemaddr` in 32: fetch word address.
- `dmemREN` in 1: data read request.
- `dmemWEN` in 1: data write request.
- `dmemaddr` in 32: data address.
- `dmemstore` in 32: write data.
- `halt` in 1: datapath halted.
- `ihit` out 1: fetch complete, 1-cycle pulse.
- `imemload` out 32: instruction word, valid with `ihit`.
- `dhit` out 1: data access complete, 1-cycle pulse.
- `dmemload` out 32: read data, valid with `dhit`.
- `ramREN` out 1, `ramWEN` out 1: RAM strobes.
- `ramaddr` out 32, `ramstore` out 32: RAM address and write data.
- `ramload` in 32: RAM read data.
- `ramready` in 1: RAM access complete, 1-cycle pulse.

## Operation
- FSM states: IDLE, IFETCH, DACCESS, RESP, HALTED.
- **IDLE**, requests sampled each cycle, in this priority order:
  - `halt` → HALTED.
  - `dmemREN|dmemWEN` → DACCESS. Latch addr, store data, and op.
  - `imemREN` with buffer hit (`FETCH_BUF`=1, buffer valid, tag==`imemaddr`) → RESP. `ihit` is asserted next cycle with the buffered word; no RAM access.
  - `imemREN` otherwise → IFETCH. Latch addr.
- **`dmemREN` and `dmemWEN` both high**: treated as a write.
- **IFETCH/DACCESS**:
  - `ramREN`/`ramWEN`, `ramaddr`, and `ramstore` are registered from the latched values.
  - They are held constant until `ramready`. Strobes drop the cycle after `ramready`.
- **On `ramready`** → RESP. Capture `ramload` for reads.
  - Fetch: fill the buffer (tag = latched addr, valid = 1).
- **RESP** (one cycle): pulse the hit only if the originating request is still asserted with the same address; otherwise discard silently. Return to IDLE.
- **Hit exclusivity**: `ihit` and `dhit` are never high in the same cycle.
- **Buffer coherence**: a data write whose address equals the buffer tag clears `valid` when the write is accepted in IDLE.
- **Write responses**: `dhit` pulses with `dmemload` unchanged.
- **`halt`** seen in IFETCH/DACCESS:
  - The in-flight RAM access runs to `ramready`.
  - The response is discarded.
  - The FSM enters HALTED, skipping RESP.
- **HALTED**: absorbing until reset. All strobes and hits stay 0.
- **Reset**: all outputs 0, buffer invalid, FSM IDLE. A mid-access reset drops the RAM strobes immediately (asynchronously).

## Timing
- **Request accepted in IDLE at edge t**:
  - RAM strobes high from t+1.
  - If `ramready` arrives at edge t+1+k (k≥0), the hit pulse is high during cycle t+2+k.
  - Total latency k+2 cycles.
- **Buffer hit**: request at t, `ihit` high during t+1.
- **Back-to-back**: the FSM is back in IDLE the cycle after RESP. A new request can be accepted then, giving a minimum 2-cycle spacing between hits.
- **Load-data hold**: `imemload` and `dmemload` are registered and hold their value until the next respective hit.
- **`ramready` outside IFETCH/DACCESS**: ignored.

## Test plan
- **RAM fetch, k=2**: reset, then `imemREN`=1, `imemaddr`=0x40, `ramload`=0xDEADBEEF. Required: `ramREN`=1, `ramaddr`=0x40 from cycle 1; `ihit`=1, `imemload`=0xDEADBEEF in cycle 4 only.
- **Arbitration**: `imemREN` and `dmemREN` raised together (imem 0x0, dmem 0x100). Required: RAM sees 0x100 first and `dhit` arrives first. The fetch of 0x0 follows, with no cycle having `ihit` and `dhit` both high.
- **Buffer hit and invalidation**:
  - Fetch 0x20 completes via RAM, then refetch 0x20. Required: `ihit` one cycle after the request, no `ramREN`.
  - Then write 0x20 (`dmemstore`=0x1234) and refetch. Required: the refetch goes to RAM.
- **Withdrawn request**: fetch 0x8 issued, then `imemREN` dropped before `ramready`. Required: RAM access completes, no `ihit`, FSM back in IDLE.
- **Halt mid-access**: `halt`=1 during DACCESS with k=3. Required: `ramWEN` held until `ramready`, no `dhit`, strobes 0 thereafter, later requests ignored.
- **Async reset mid-access**: `nRST` low during IFETCH between clock edges. Required: `ramREN`, `ihit`, and `dhit` go to 0 immediately. After release, the buffer is empty (the first fetch goes to RAM).
